i2c_master_burst: RTL and testbench

I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

---
 rtl/i2c_master_burst.sv | 225 ++++++++++++++++++++++
 tb/tb_i2c_master_burst.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_burst.sv
`default_nettype none
// ============================================================================
// Module  : i2c_master_burst
// Brief   : Single-master I2C engine issuing multi-byte write or read bursts.
//           SCL/SDA are open-drain: *_oe=1 pulls the line low.
//           Each bit is four quarter-period ticks; SCL is low in phases 0-1
//           and released in phases 2-3, SDA moves at phase 0 and is sampled
//           at phase 2.
// Revision: 1.0  initial release
// ============================================================================
module i2c_master_burst #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       wr,
   input  logic [6:0] addr,
   input  logic [7:0] len,
   input  logic [7:0] din,
   output logic       din_req,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_i
);

   localparam int            DW        = $clog2(CLK_DIV);
   localparam int            CW        = $clog2(MAX_LEN + 1);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_START = 4'd1,
      ST_ADDR  = 4'd2,
      ST_ACK1  = 4'd3,
      ST_WDATA = 4'd4,
      ST_ACK2  = 4'd5,
      ST_RDATA = 4'd6,
      ST_MACK  = 4'd7,
      ST_STOP  = 4'd8
   } state_t;

   state_t        state_q;
   logic [DW-1:0] div_q;
   logic [1:0]    phase_q;
   logic [2:0]    bit_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    tx_q;
   logic [7:0]    wbyte_q;
   logic [7:0]    rx_q;
   logic          wr_q;
   logic          ack_q;
   logic          tick;
   logic          len_ok;

   // Quarter-bit tick, only generated while a transfer is running
   assign tick   = busy && (div_q == DIV_LAST);
   // A request is only legal for 1..MAX_LEN bytes
   assign len_ok = (len != 8'd0) && (len <= MAX_LEN_B);

   // Bus sequencer: accepts requests, walks the bit phases, drives the lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         phase_q    <= 2'd0;
         bit_q      <= 3'd0;
         cnt_q      <= '0;
         tx_q       <= 8'h00;
         wbyte_q    <= 8'h00;
         rx_q       <= 8'h00;
         wr_q       <= 1'b0;
         ack_q      <= 1'b0;
         din_req    <= 1'b0;
         dout       <= 8'h00;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ack_err    <= 1'b0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
      end else begin
         done       <= 1'b0;
         din_req    <= 1'b0;
         dout_valid <= 1'b0;
         // The next write byte is presented during the din_req cycle
         if (din_req) wbyte_q <= din;

         if (!busy) begin
            div_q <= '0;
            if (start && len_ok) begin
               // START condition: SDA falls while SCL stays released for two ticks
               busy    <= 1'b1;
               state_q <= ST_START;
               phase_q <= 2'd2;
               ack_err <= 1'b0;
               wr_q    <= wr;
               tx_q    <= {addr, ~wr};
               wbyte_q <= din;
               cnt_q   <= len[CW-1:0];
               bit_q   <= 3'd0;
               scl_oe  <= 1'b0;
               sda_oe  <= 1'b1;
            end
         end else begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
               phase_q <= phase_q + 2'd1;
               case (phase_q)
                  2'd1: scl_oe <= 1'b0;
                  2'd2: begin
                     case (state_q)
                        ST_ACK1: ack_q <= sda_i;
                        ST_ACK2: begin
                           ack_q <= sda_i;
                           if (!sda_i) begin
                              if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                              if (cnt_q > CW'(1)) din_req <= 1'b1;
                           end
                        end
                        ST_RDATA: begin
                           rx_q <= {rx_q[6:0], sda_i};
                           if (bit_q == 3'd7) begin
                              dout       <= {rx_q[6:0], sda_i};
                              dout_valid <= 1'b1;
                              if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                           end
                        end
                        // STOP condition: SDA rises while SCL is released
                        ST_STOP: sda_oe <= 1'b0;
                        default: ;
                     endcase
                  end
                  2'd3: begin
                     scl_oe <= 1'b1;
                     case (state_q)
                        ST_START: begin
                           state_q <= ST_ADDR;
                           bit_q   <= 3'd0;
                           sda_oe  <= ~tx_q[7];
                        end
                        ST_ADDR, ST_WDATA: begin
                           if (bit_q == 3'd7) begin
                              state_q <= (state_q == ST_ADDR) ? ST_ACK1 : ST_ACK2;
                              bit_q   <= 3'd0;
                              sda_oe  <= 1'b0;
                           end else begin
                              bit_q  <= bit_q + 3'd1;
                              tx_q   <= {tx_q[6:0], 1'b0};
                              sda_oe <= ~tx_q[6];
                           end
                        end
                        ST_ACK1: begin
                           if (ack_q) begin
                              ack_err <= 1'b1;
                              state_q <= ST_STOP;
                              sda_oe  <= 1'b1;
                           end else if (wr_q) begin
                              state_q <= ST_WDATA;
                              tx_q    <= wbyte_q;
                              sda_oe  <= ~wbyte_q[7];
                           end else begin
                              state_q <= ST_RDATA;
                              sda_oe  <= 1'b0;
                           end
                        end
                        ST_ACK2: begin
                           if (ack_q) begin
                              ack_err <= 1'b1;
                              state_q <= ST_STOP;
                              sda_oe  <= 1'b1;
                           end else if (cnt_q != '0) begin
                              state_q <= ST_WDATA;
                              tx_q    <= wbyte_q;
                              sda_oe  <= ~wbyte_q[7];
                           end else begin
                              state_q <= ST_STOP;
                              sda_oe  <= 1'b1;
                           end
                        end
                        ST_RDATA: begin
                           if (bit_q == 3'd7) begin
                              state_q <= ST_MACK;
                              bit_q   <= 3'd0;
                              // ACK (pull low) only if more bytes are wanted
                              sda_oe  <= (cnt_q != '0);
                           end else begin
                              bit_q <= bit_q + 3'd1;
                           end
                        end
                        ST_MACK: begin
                           if (cnt_q != '0) begin
                              state_q <= ST_RDATA;
                              sda_oe  <= 1'b0;
                           end else begin
                              state_q <= ST_STOP;
                              sda_oe  <= 1'b1;
                           end
                        end
                        ST_STOP: begin
                           state_q <= ST_IDLE;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           scl_oe  <= 1'b0;
                           sda_oe  <= 1'b0;
                        end
                        default: state_q <= ST_IDLE;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_i2c_master_burst
// Brief   : Self-checking bench for i2c_master_burst. A transfer is described
//           as a list of bit slots; the expected line/handshake levels for
//           every clk follow from the slot list by timing arithmetic.
// Revision: 1.0  initial release
// ============================================================================
module tb_i2c_master_burst;

   localparam int CD = 4;
   localparam int ML = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       wr    = 1'b0;
   logic [6:0] addr  = 7'h00;
   logic [7:0] len   = 8'h00;
   logic [7:0] din   = 8'h00;
   logic       din_req, dout_valid, busy, done, ack_err, scl_oe, sda_oe, sda_i;
   logic [7:0] dout;
   logic       slave_pull = 1'b0;

   // Open-drain SDA: low if either side pulls
   assign sda_i = ~(sda_oe | slave_pull);

   i2c_master_burst #(.CLK_DIV(CD), .MAX_LEN(ML)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .addr(addr),
      .len(len), .din(din), .din_req(din_req), .dout(dout),
      .dout_valid(dout_valid), .busy(busy), .done(done), .ack_err(ack_err),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
   );

   always #5 clk = ~clk;

   // One bit slot on the bus: master SDA enable, slave pull, STOP slot,
   // din_req expected, dout_valid expected with value
   typedef struct packed {
      logic       moe;
      logic       spull;
      logic       stp;
      logic       dreq;
      logic       dval;
      logic [7:0] dv;
   } slot_t;

   slot_t      sl[$];
   logic [7:0] bytes [4];
   int         checks = 0;
   int         errors = 0;
   bit         mon_on = 1'b0;
   int         k = 0;
   int         end_k = 0;
   int         err_k = 0;
   int         widx = 0;
   int         n_dreq = 0;
   int         n_done = 0;
   bit         cap[$];
   int         rise_k[$];
   logic [7:0] rx[$];
   logic       scl_prev = 1'b0;

   int         q, s, p;
   logic       first;
   logic [6:0] ev, av;
   slot_t      cur;

   function automatic void add(input logic moe, input logic spull, input logic stp,
                               input logic dreq, input logic dval, input logic [7:0] dv);
      slot_t x;
      x.moe = moe; x.spull = spull; x.stp = stp; x.dreq = dreq; x.dval = dval; x.dv = dv;
      sl.push_back(x);
   endfunction

   // nack_at: -1 none, 0 address NACK, j+1 NACK on data byte j
   task automatic build(input logic w, input logic [6:0] a, input int n, input int nack_at);
      logic [7:0] ab;
      int         s_err;
      ab    = {a, ~w};
      s_err = -1;
      sl.delete();
      for (int i = 7; i >= 0; i--) add(~ab[i], 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (nack_at == 0) begin
         s_err = sl.size();
         add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end else begin
         add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
         for (int j = 0; j < n; j++) begin
            for (int i = 7; i >= 0; i--) begin
               if (w) add(~bytes[j][i], 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
               else   add(1'b0, ~bytes[j][i], 1'b0, 1'b0, (i == 0), bytes[j]);
            end
            if (w) begin
               if (nack_at == j + 1) begin
                  s_err = sl.size();
                  add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                  break;
               end
               add(1'b0, 1'b1, 1'b0, (j < n - 1), 1'b0, 8'h00);
            end else begin
               add((j < n - 1), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end
         end
      end
      add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      err_k = (s_err < 0) ? 32'h3FFF_FFFF : (2 + 4 * (s_err + 1)) * CD + 1;
      end_k = (2 + 4 * sl.size()) * CD + 1;
   endtask

   // Per-cycle compare against the slot model, plus slave and din responder
   always @(negedge clk) begin
      if (mon_on) begin
         k = k + 1;
         if (scl_prev && !scl_oe) begin
            cap.push_back(sda_i);
            rise_k.push_back(k);
         end
         q   = (k - 1) / CD;
         cur = '0;
         ev  = 7'b0;
         if (q < 2) begin
            ev[6:1] = 6'b011000;
         end else begin
            s = (q - 2) / 4;
            p = (q - 2) % 4;
            if (s < sl.size()) begin
               cur   = sl[s];
               first = (p == 3) && (((k - 1) % CD) == 0);
               ev[6] = (p < 2);
               ev[5] = (cur.stp && p == 3) ? 1'b0 : cur.moe;
               ev[4] = 1'b1;
               ev[2] = cur.dreq & first;
               ev[1] = cur.dval & first;
            end else begin
               ev[3] = 1'b1;
            end
         end
         ev[0] = (k >= err_k);
         av = {scl_oe, sda_oe, busy, done, din_req, dout_valid, ack_err};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL cycle k=%0d scl/sda/busy/done/dreq/dval/err: got %b, expected %b",
                     k, av, ev);
         end
         if (ev[1]) begin
            checks++;
            if (dout !== cur.dv) begin
               errors++;
               $display("FAIL dout k=%0d: got %h, expected %h", k, dout, cur.dv);
            end
         end
         if (dout_valid) rx.push_back(dout);
         if (din_req) begin
            n_dreq++;
            if (widx < 3) widx++;
            din = bytes[widx];
         end
         if (done) n_done++;
         slave_pull = cur.spull;
         if (k >= end_k) begin
            mon_on     = 1'b0;
            slave_pull = 1'b0;
         end
      end
      scl_prev = scl_oe;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] capv();
      logic [63:0] v;
      v = 64'd0;
      foreach (cap[i]) v = {v[62:0], cap[i]};
      return v;
   endfunction

   task automatic launch(input logic w, input logic [6:0] a, input int n, input int nack_at);
      build(w, a, n, nack_at);
      cap.delete(); rise_k.delete(); rx.delete();
      n_dreq = 0; n_done = 0; widx = 0;
      @(negedge clk);
      wr = w; addr = a; len = 8'(n); din = bytes[0]; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k = 0;
      mon_on = 1'b1;
   endtask

   // inj_k: nonzero pulses a competing start request at that model cycle
   task automatic run(input logic w, input logic [6:0] a, input int n, input int nack_at,
                      input int inj_k);
      int t;
      launch(w, a, n, nack_at);
      t = 0;
      while (mon_on && t < end_k + 100) begin
         @(posedge clk);
         #1;
         t++;
         if (inj_k != 0 && k == inj_k) begin
            start = 1'b1; wr = ~w; addr = 7'h7F; len = 8'd1; din = 8'hFF;
            @(posedge clk);
            #1 start = 1'b0;
            t++;
         end
      end
      if (mon_on) begin
         mon_on = 1'b0;
         chk("xfer_timeout", 64'd1, 64'd0);
      end
   endtask

   task automatic idle_chk(input string nm, input int cycles);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (busy || scl_oe || sda_oe || done || din_req || dout_valid) bad = 1'b1;
      end
      chk(nm, 64'(bad), 64'd0);
   endtask

   task automatic bad_start(input logic [7:0] l);
      @(negedge clk);
      wr = 1'b1; addr = 7'h50; len = l; din = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int t;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", 64'({scl_oe, sda_oe, busy, done, din_req, dout_valid, ack_err, dout}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Two-byte write, all ACKed
      bytes = '{8'hA5, 8'hC3, 8'h00, 8'h00};
      run(1'b1, 7'h50, 2, -1, 0);
      chk("w2_bits",   capv(), 64'(28'b1010000_0_0_10100101_0_11000011_0_0));
      chk("w2_nbits",  64'(cap.size()), 64'd28);
      chk("w2_period", 64'((rise_k.size() > 1) ? rise_k[1] - rise_k[0] : 0), 64'd16);
      chk("w2_dreq",   64'(n_dreq), 64'd1);
      chk("w2_done",   64'(n_done), 64'd1);
      chk("w2_ackerr", 64'(ack_err), 64'd0);

      // Address NACK on a write
      run(1'b1, 7'h22, 1, 0, 0);
      chk("anack_bits", capv(), 64'(10'b0100010_0_1_0));
      chk("anack_err",  64'(ack_err), 64'd1);
      chk("anack_dreq", 64'(n_dreq), 64'd0);
      chk("anack_done", 64'(n_done), 64'd1);

      // Three-byte read: master ACK, ACK, NACK
      bytes = '{8'h12, 8'h34, 8'h56, 8'h00};
      run(1'b0, 7'h51, 3, -1, 0);
      chk("rd_bits",  capv(), 64'(37'b1010001_1_0_00010010_0_00110100_0_01010110_1_0));
      chk("rd_count", 64'(rx.size()), 64'd3);
      chk("rd_b0",    64'((rx.size() > 0) ? rx[0] : 8'h00), 64'h12);
      chk("rd_b1",    64'((rx.size() > 1) ? rx[1] : 8'h00), 64'h34);
      chk("rd_b2",    64'((rx.size() > 2) ? rx[2] : 8'h00), 64'h56);
      chk("rd_done",  64'(n_done), 64'd1);

      // Three-byte write, slave NACKs byte 1
      bytes = '{8'hAA, 8'h55, 8'h0F, 8'h00};
      run(1'b1, 7'h3C, 3, 2, 0);
      chk("dnack_bits", capv(), 64'(28'b0111100_0_0_10101010_0_01010101_1_0));
      chk("dnack_dreq", 64'(n_dreq), 64'd1);
      chk("dnack_err",  64'(ack_err), 64'd1);

      // Illegal lengths are ignored
      bad_start(8'd0);
      idle_chk("len0_ignored", 24);
      bad_start(8'(ML + 1));
      idle_chk("len_over_ignored", 24);
      chk("len_bad_err_kept", 64'(ack_err), 64'd1);

      // Competing start while busy leaves the transfer untouched
      bytes = '{8'hA5, 8'hC3, 8'h00, 8'h00};
      run(1'b1, 7'h50, 2, -1, 60);
      chk("inj_bits", capv(), 64'(28'b1010000_0_0_10100101_0_11000011_0_0));
      chk("inj_dreq", 64'(n_dreq), 64'd1);
      idle_chk("inj_no_retrigger", 40);

      // Reset in the middle of a read (byte 1, bit 4)
      bytes = '{8'h12, 8'h34, 8'h56, 8'h00};
      launch(1'b0, 7'h51, 3, -1);
      t = 0;
      while (k < (2 + 4 * 22) * CD + 1 && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("rst_pre", 64'({scl_oe, busy, dout}), 64'({1'b1, 1'b1, 8'h12}));
      mon_on = 1'b0;
      slave_pull = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async", 64'({scl_oe, sda_oe, busy, done, din_req, dout_valid, ack_err, dout}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle_chk("rst_no_stop", 8);

      // First transfer after reset
      bytes = '{8'h81, 8'h00, 8'h00, 8'h00};
      run(1'b1, 7'h10, 1, -1, 0);
      chk("post_rst_bits", capv(), 64'(19'b0010000_0_0_10000001_0_0));
      chk("post_rst_done", 64'(n_done), 64'd1);
      chk("post_rst_dreq", 64'(n_dreq), 64'd0);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
